// File: rtl/kernel_call_pkg.sv
// rtl/kernel_call_pkg.sv - shared state encoding and default widths for the kernel call controller
package kernel_call_pkg;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_CYC_W   = 32;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LAUNCH = 4'b0010,
    ST_WAIT   = 4'b0100,
    ST_RESP   = 4'b1000
  } state_t;

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/kernel_call_watchdog.sv
// rtl/kernel_call_watchdog.sv - per-invocation watchdog counting non-stalled wait cycles
module call_watchdog
  import kernel_call_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int WD_W = wd_width(TIMEOUT);

  logic [WD_W-1:0] count;

  // Fires during the enabled cycle that brings the count to TIMEOUT, so a finish
  // in that same cycle (which drops enable) naturally takes priority.
  assign expired = enable && (count == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WD_W'(1);
    end
  end

endmodule

// File: rtl/kernel_call_ctrl.sv
// rtl/kernel_call_ctrl.sv - host-side initiator issuing N start/finish handshakes to one kernel FSM
module kernel_call_ctrl
  import kernel_call_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int CYC_W   = DEF_CYC_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             callee_start,
  input  logic             callee_finish,
  input  logic             mem_stall,
  output logic             callee_stall,
  output logic             done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] iter_done,
  output logic [CYC_W-1:0] cycle_count
);

  state_t           state;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] iter_next;
  logic             wd_clear;
  logic             wd_enable;
  logic             wd_expired;

  assign callee_stall = mem_stall;
  assign cmd_ready    = (state == ST_IDLE);
  assign callee_start = (state == ST_LAUNCH);
  assign done         = (state == ST_RESP);
  assign iter_next    = iter_done + CNT_W'(1);

  // The kernel samples start on the first unstalled edge, which is when the watchdog restarts.
  assign wd_clear  = (state == ST_IDLE) || ((state == ST_LAUNCH) && !mem_stall);
  assign wd_enable = (state == ST_WAIT) && !mem_stall && !callee_finish;

  call_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      count_q     <= '0;
      iter_done   <= '0;
      cycle_count <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (((state == ST_LAUNCH) || (state == ST_WAIT)) && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CYC_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            count_q     <= cmd_count;
            iter_done   <= '0;
            cycle_count <= '0;
            err_timeout <= 1'b0;
            state       <= (cmd_count == '0) ? ST_RESP : ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (!mem_stall) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (callee_finish) begin
            iter_done <= iter_next;
            state     <= (iter_next == count_q) ? ST_RESP : ST_LAUNCH;
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_call_ctrl.sv
// tb/tb_kernel_call_ctrl.sv - self-checking bench for kernel_call_ctrl with a kernel stub and reference model
module tb_kernel_call_ctrl;

  localparam int CNT_W   = 16;
  localparam int CYC_W   = 32;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic             callee_start;
  logic             callee_finish;
  logic             mem_stall;
  logic             callee_stall;
  logic             done;
  logic             err_timeout;
  logic [CNT_W-1:0] iter_done;
  logic [CYC_W-1:0] cycle_count;

  logic kern_fin  = 1'b0;
  logic stray_fin = 1'b0;
  assign callee_finish = kern_fin | stray_fin;

  kernel_call_ctrl #(
    .CNT_W  (CNT_W),
    .CYC_W  (CYC_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_count    (cmd_count),
    .callee_start (callee_start),
    .callee_finish(callee_finish),
    .mem_stall    (mem_stall),
    .callee_stall (callee_stall),
    .done         (done),
    .err_timeout  (err_timeout),
    .iter_done    (iter_done),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Kernel stub: takes a start on an unstalled edge, raises finish klen cycles later.
  int klen  = 5;
  int kstate = 0;
  logic took = 1'b0;

  initial forever begin
    @(negedge clk);
    took = callee_start && !mem_stall && !reset;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (reset) begin
      kstate   = 0;
      kern_fin = 1'b0;
    end else begin
      if (took) kstate = 1;
      else if (kstate != 0) kstate = (kstate >= klen) ? 0 : kstate + 1;
      kern_fin = (klen != 0) && (kstate == klen);
    end
  end

  // Reference model: command-level bookkeeping, advanced once per cycle.
  bit     m_busy, m_start_pending, m_resp, m_err;
  int     m_target, m_iter, m_wd;
  longint m_cyc;

  task automatic m_reset();
    m_busy = 0; m_start_pending = 0; m_resp = 0; m_err = 0;
    m_target = 0; m_iter = 0; m_wd = 0; m_cyc = 0;
  endtask

  task automatic m_advance();
    if (m_resp) begin
      m_resp = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_target = int'(cmd_count);
        m_iter = 0; m_cyc = 0; m_err = 0; m_busy = 1;
        if (cmd_count == 0) m_resp = 1;
        else m_start_pending = 1;
      end
    end else begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (m_start_pending) begin
        if (!mem_stall) begin
          m_start_pending = 0;
          m_wd = 0;
        end
      end else if (callee_finish) begin
        m_iter = (m_iter + 1) % 65536;
        if (m_iter == m_target) m_resp = 1;
        else m_start_pending = 1;
      end else if (!mem_stall) begin
        m_wd++;
        if (m_wd == TIMEOUT) begin
          m_err = 1;
          m_resp = 1;
        end
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (reset) begin
        m_reset();
      end else begin
        check("cmd_ready", cmd_ready, !m_busy);
        check("callee_start", callee_start, m_start_pending);
        check("done", done, m_resp);
        check("err_timeout", err_timeout, m_err);
        check("iter_done", iter_done, m_iter);
        check("cycle_count", cycle_count, m_cyc);
        check("callee_stall", callee_stall, mem_stall);
        m_advance();
      end
    end
  end

  int lat, start_hi, start_rises;

  task automatic run_cmd(input int n, input int kl, input int s_from, input int s_to);
    int a, rel;
    bit got, prev;
    klen = kl;
    got = 0; prev = 0; start_hi = 0; start_rises = 0; lat = -1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_count = CNT_W'(n);
    a = cyc;
    for (int k = 0; k < 300 && !got; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      cmd_valid = (k == 0);
      rel = cyc - a;
      mem_stall = (rel >= s_from) && (rel <= s_to);
      @(negedge clk);
      if (callee_start) start_hi++;
      if (callee_start && !prev) start_rises++;
      prev = callee_start;
      if (done) begin
        got = 1;
        lat = rel;
      end
    end
    if (!got) check("done_seen", 0, 1);
  endtask

  int done_cnt;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_count = '0; mem_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_start", callee_start, 0);
    check("rst_done", done, 0);

    // single call, no stall
    run_cmd(1, 5, 1, 0);
    check("t1_lat", lat, 7);
    check("t1_start_hi", start_hi, 1);
    check("t1_iter", iter_done, 1);
    check("t1_cyc", cycle_count, 6);
    check("t1_err", err_timeout, 0);

    // start held under stall
    run_cmd(1, 5, 1, 3);
    check("t2_lat", lat, 10);
    check("t2_start_hi", start_hi, 4);
    check("t2_cyc", cycle_count, 9);

    // three back-to-back calls
    run_cmd(3, 5, 1, 0);
    check("t3_lat", lat, 19);
    check("t3_rises", start_rises, 3);
    check("t3_iter", iter_done, 3);
    check("t3_cyc", cycle_count, 18);

    // watchdog with two stalled wait cycles that must not count
    run_cmd(1, 0, 4, 5);
    check("t5_lat", lat, 12);
    check("t5_err", err_timeout, 1);
    check("t5_iter", iter_done, 0);
    check("t5_cyc", cycle_count, 11);

    // finish while idle is ignored
    @(posedge clk); #1; stray_fin = 1'b1;
    @(posedge clk); #1; stray_fin = 1'b0;

    // zero-count command
    run_cmd(0, 5, 1, 0);
    check("t4_lat", lat, 1);
    check("t4_start_hi", start_hi, 0);
    check("t4_iter", iter_done, 0);
    check("t4_cyc", cycle_count, 0);
    check("t4_err_cleared", err_timeout, 0);

    // finish lands on the last watchdog cycle
    run_cmd(1, 8, 1, 0);
    check("t6_lat", lat, 10);
    check("t6_err", err_timeout, 0);
    check("t6_iter", iter_done, 1);
    check("t6_cyc", cycle_count, 9);

    // async reset in the middle of the second call's wait
    klen = 5;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_count = CNT_W'(3);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k < 9; k++) @(posedge clk);
    @(negedge clk);
    check("t7_pre_iter", iter_done, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t7_rst_ready", cmd_ready, 1);
    check("t7_rst_start", callee_start, 0);
    check("t7_rst_done", done, 0);
    check("t7_rst_iter", iter_done, 0);
    check("t7_rst_cyc", cycle_count, 0);
    check("t7_rst_err", err_timeout, 0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    #2;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("t7_no_done", done_cnt, 0);
    check("t7_ready_after", cmd_ready, 1);
    run_cmd(1, 5, 1, 0);
    check("t7_lat", lat, 7);
    check("t7_iter", iter_done, 1);
    check("t7_cyc", cycle_count, 6);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
